// File: rtl/coeff_loader.sv
// Byte-stream loader for filter coefficient banks: frames are assembled in a
// shadow buffer, checksum-verified, then committed atomically into one band.
//
// state    | meaning
// S_IDLE   | waiting for a header byte 0xA0|band
// S_RX_HI  | expecting coefficient MSB byte
// S_RX_LO  | expecting coefficient LSB byte, writes shadow word
// S_RX_CHK | expecting XOR checksum byte
// S_COMMIT | copying shadow into the live band (in_ready low)
module coeff_loader #(
   parameter int FILTER_SIZE = 100,
   parameter int AUDIO_DEPTH = 16,
   parameter int NUM_BANDS   = 3,
   parameter int TIMEOUT     = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [AUDIO_DEPTH-1:0] coeff [0:NUM_BANDS-1][0:FILTER_SIZE],
   output logic [NUM_BANDS-1:0]   bank_valid,
   output logic                   load_busy,
   output logic                   load_done,
   output logic                   load_error
);
   localparam int IW = (FILTER_SIZE > 0) ? $clog2(FILTER_SIZE + 1) : 1;
   localparam int BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(FILTER_SIZE);
   localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_RX_HI, S_RX_LO, S_RX_CHK, S_COMMIT} state_t;

   state_t                 state_q;
   logic [IW-1:0]          idx_q;
   logic [7:0]             hi_q;
   logic [7:0]             xor_q;
   logic [BW-1:0]          band_q;
   logic [CW-1:0]          tmo_q;
   logic [AUDIO_DEPTH-1:0] shadow_q [0:FILTER_SIZE];
   logic                   hs;
   logic                   hdr_ok;

   assign in_ready  = !rst && (state_q != S_COMMIT);
   assign hs        = in_valid && in_ready;
   assign hdr_ok    = (in_data[7:4] == 4'hA) && ({28'd0, in_data[3:0]} < NUM_BANDS);
   assign load_busy = (state_q != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         hi_q       <= '0;
         xor_q      <= '0;
         band_q     <= '0;
         tmo_q      <= '0;
         bank_valid <= '0;
         load_done  <= 1'b0;
         load_error <= 1'b0;
         for (int t = 0; t <= FILTER_SIZE; t++) shadow_q[t] <= '0;
         for (int b = 0; b < NUM_BANDS; b++)
            for (int t = 0; t <= FILTER_SIZE; t++) coeff[b][t] <= '0;
      end else begin
         load_done  <= 1'b0;
         load_error <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (hs) begin
                  if (hdr_ok) begin
                     state_q <= S_RX_HI;
                     idx_q   <= '0;
                     xor_q   <= '0;
                     band_q  <= in_data[BW-1:0];
                     tmo_q   <= TMO_LOAD;
                  end else begin
                     load_error <= 1'b1;
                  end
               end
            end
            S_RX_HI, S_RX_LO, S_RX_CHK: begin
               if (hs) begin
                  tmo_q <= TMO_LOAD;
                  case (state_q)
                     S_RX_HI: begin
                        hi_q    <= in_data;
                        xor_q   <= xor_q ^ in_data;
                        state_q <= S_RX_LO;
                     end
                     S_RX_LO: begin
                        shadow_q[idx_q] <= AUDIO_DEPTH'({hi_q, in_data});
                        xor_q           <= xor_q ^ in_data;
                        if (idx_q == LAST_IDX) begin
                           state_q <= S_RX_CHK;
                        end else begin
                           idx_q   <= idx_q + 1'b1;
                           state_q <= S_RX_HI;
                        end
                     end
                     default: begin
                        if (in_data == xor_q) begin
                           state_q <= S_COMMIT;
                        end else begin
                           state_q    <= S_IDLE;
                           load_error <= 1'b1;
                        end
                     end
                  endcase
               end else if (tmo_q == '0) begin
                  // idle-gap watchdog is the only way to resync a broken frame
                  state_q    <= S_IDLE;
                  load_error <= 1'b1;
               end else begin
                  tmo_q <= tmo_q - 1'b1;
               end
            end
            S_COMMIT: begin
               for (int t = 0; t <= FILTER_SIZE; t++) coeff[band_q][t] <= shadow_q[t];
               bank_valid[band_q] <= 1'b1;
               load_done          <= 1'b1;
               state_q            <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_coeff_loader.sv
// Randomized directed bench for coeff_loader: frames built from random tap
// tables, checked against an array model of the live banks and pulse timing.
module tb_coeff_loader;
   localparam int FS = 100;
   localparam int AD = 16;
   localparam int NB = 3;
   localparam int TO = 1024;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AD-1:0] coeff [0:NB-1][0:FS];
   logic [NB-1:0] bank_valid;
   logic          load_busy;
   logic          load_done;
   logic          load_error;

   coeff_loader #(
      .FILTER_SIZE(FS), .AUDIO_DEPTH(AD), .NUM_BANDS(NB), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .coeff(coeff), .bank_valid(bank_valid),
      .load_busy(load_busy), .load_done(load_done), .load_error(load_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int done_cnt = 0, err_cnt = 0, both_cnt = 0, rdy_low = 0;
   always @(negedge clk) begin
      if (load_done) done_cnt <= done_cnt + 1;
      if (load_error) err_cnt <= err_cnt + 1;
      if (load_done && load_error) both_cnt <= both_cnt + 1;
      if (!rst && !in_ready) rdy_low <= rdy_low + 1;
   end

   int n_total = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_total++;
      assert (obs === want) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
   endtask

   // reference model: live banks and valid bits as plain arrays
   logic [15:0]   exp_coeff [NB][FS+1];
   logic [NB-1:0] exp_bv;
   logic [15:0]   taps [FS+1];
   logic [7:0]    q [$];
   int            hs_cycle;

   task automatic model_reset();
      for (int b = 0; b < NB; b++)
         for (int t = 0; t <= FS; t++) exp_coeff[b][t] = 16'h0000;
      exp_bv = '0;
   endtask

   task automatic model_commit(input int band);
      for (int t = 0; t <= FS; t++) exp_coeff[band][t] = taps[t];
      exp_bv[band] = 1'b1;
   endtask

   task automatic check_model(input string tag);
      for (int b = 0; b < NB; b++)
         for (int t = 0; t <= FS; t++)
            chk($sformatf("%s coeff[%0d][%0d]", tag, b, t), 32'(coeff[b][t]), 32'(exp_coeff[b][t]));
      chk({tag, " bank_valid"}, 32'(bank_valid), 32'(exp_bv));
   endtask

   task automatic new_taps();
      for (int t = 0; t <= FS; t++) taps[t] = 16'($urandom);
   endtask

   task automatic build(input int band, input bit bad);
      logic [7:0] x;
      x = 8'h00;
      q.push_back(8'hA0 | 8'(band));
      for (int t = 0; t <= FS; t++) begin
         q.push_back(taps[t][15:8]);
         q.push_back(taps[t][7:0]);
         x = x ^ taps[t][15:8] ^ taps[t][7:0];
      end
      q.push_back(bad ? ~x : x);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok;
      int w;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = b;
      w = 0;
      ok = 1'b0;
      while (!ok) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         w++;
         if (!ok && w > 50) begin
            $display("FAIL handshake_wait: observed no in_ready within 50 cycles, expected ready");
            $fatal(1, "handshake stalled");
         end
      end
      hs_cycle = cyc - 1;
      in_valid = 1'b0;
   endtask

   task automatic send_q(input int first, input int last_excl, input int max_gap);
      for (int i = first; i < last_excl; i++) send_byte(q[i], int'($urandom_range(0, max_gap)));
   endtask

   task automatic wait_pulse(input bit want_done, input int budget, output int at);
      at = -1000000;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (want_done ? load_done : load_error) begin
            at = cyc;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int at, d0, e0;
      model_reset();

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst in_ready", 32'(in_ready), 0);
      chk("rst load_busy", 32'(load_busy), 0);
      chk("rst load_done", 32'(load_done), 0);
      chk("rst load_error", 32'(load_error), 0);
      check_model("rst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post-rst in_ready", 32'(in_ready), 1);
      chk("post-rst load_busy", 32'(load_busy), 0);
      @(posedge clk); #1;

      // full band-1 load with the two fixed equalizer taps
      new_taps();
      taps[50] = 16'h0099;
      taps[48] = 16'hFF7F;
      q.delete();
      build(1, 1'b0);
      d0 = done_cnt;
      send_q(0, 5, 2);
      chk("b1 busy mid-frame", 32'(load_busy), 1);
      send_q(5, q.size(), 2);
      wait_pulse(1'b1, 10, at);
      chk("b1 done latency", 32'(at - hs_cycle), 2);
      model_commit(1);
      check_model("b1");
      repeat (3) @(posedge clk); #1;
      chk("b1 done count", 32'(done_cnt - d0), 1);
      chk("b1 busy after", 32'(load_busy), 0);

      // band-0 frame with inverted checksum, then the same frame correct
      new_taps();
      q.delete();
      build(0, 1'b1);
      e0 = err_cnt;
      d0 = done_cnt;
      send_q(0, q.size(), 1);
      wait_pulse(1'b0, 10, at);
      chk("cksum err latency", 32'(at - hs_cycle), 1);
      repeat (3) @(posedge clk); #1;
      chk("cksum err count", 32'(err_cnt - e0), 1);
      chk("cksum no done", 32'(done_cnt - d0), 0);
      chk("cksum busy", 32'(load_busy), 0);
      check_model("cksum");
      q.delete();
      build(0, 1'b0);
      send_q(0, q.size(), 1);
      wait_pulse(1'b1, 10, at);
      chk("b0 done latency", 32'(at - hs_cycle), 2);
      model_commit(0);
      check_model("b0");

      // bad headers: out-of-range band, then a non-header byte
      e0 = err_cnt;
      d0 = done_cnt;
      send_byte(8'hA3, 0);
      wait_pulse(1'b0, 10, at);
      chk("hdr A3 err latency", 32'(at - hs_cycle), 1);
      chk("hdr A3 busy", 32'(load_busy), 0);
      send_byte(8'h55, 1);
      wait_pulse(1'b0, 10, at);
      chk("hdr 55 err latency", 32'(at - hs_cycle), 1);
      chk("hdr 55 busy", 32'(load_busy), 0);
      repeat (3) @(posedge clk); #1;
      chk("hdr err count", 32'(err_cnt - e0), 2);
      chk("hdr no done", 32'(done_cnt - d0), 0);

      // timeout after header + 10 bytes of band 2
      new_taps();
      q.delete();
      build(2, 1'b0);
      e0 = err_cnt;
      send_q(0, 11, 2);
      chk("tmo busy before", 32'(load_busy), 1);
      wait_pulse(1'b0, TO + 20, at);
      chk("tmo err latency", 32'(at - hs_cycle), TO + 1);
      chk("tmo busy after", 32'(load_busy), 0);
      repeat (3) @(posedge clk); #1;
      chk("tmo err count", 32'(err_cnt - e0), 1);
      check_model("tmo");

      // reset after 150 bytes of a band-0 frame, then a fresh frame
      new_taps();
      q.delete();
      build(0, 1'b0);
      send_q(0, 150, 1);
      chk("mid-rst busy before", 32'(load_busy), 1);
      e0 = err_cnt;
      d0 = done_cnt;
      rst = 1'b1;
      #1;
      model_reset();
      chk("mid-rst in_ready", 32'(in_ready), 0);
      chk("mid-rst busy", 32'(load_busy), 0);
      chk("mid-rst done", 32'(load_done), 0);
      chk("mid-rst error", 32'(load_error), 0);
      check_model("mid-rst");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk); #1;
      chk("mid-rst no err pulse", 32'(err_cnt - e0), 0);
      chk("mid-rst no done pulse", 32'(done_cnt - d0), 0);
      send_q(0, q.size(), 1);
      wait_pulse(1'b1, 10, at);
      chk("fresh b0 done latency", 32'(at - hs_cycle), 2);
      model_commit(0);
      check_model("fresh b0");

      // back-to-back band 2 then band 0, random gaps
      q.delete();
      new_taps();
      build(2, 1'b0);
      model_commit(2);
      new_taps();
      build(0, 1'b0);
      model_commit(0);
      d0 = done_cnt;
      send_q(0, q.size(), 3);
      for (int i = 0; i < 20 && (done_cnt - d0) < 2; i++) begin @(posedge clk); #1; end
      repeat (2) @(posedge clk); #1;
      chk("b2b done count", 32'(done_cnt - d0), 2);
      check_model("b2b");

      repeat (3) @(posedge clk); #1;
      chk("done/error overlap", 32'(both_cnt), 0);
      chk("in_ready low cycles", 32'(rdy_low), 32'(done_cnt));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
